// File: rtl/noc_flit_pkg.sv
// Shared NoC flit definitions: widths, field positions, idle flit, sink FSM encoding.
package noc_flit_pkg;

  localparam int unsigned FLIT_W   = 20;
  localparam int unsigned CTRL_MSB = 19;
  localparam int unsigned CTRL_LSB = 16;
  localparam int unsigned SRC_MSB  = 15;
  localparam int unsigned SRC_LSB  = 12;
  localparam int unsigned TAG_MSB  = 11;
  localparam int unsigned TAG_LSB  = 8;
  localparam int unsigned DEST_MSB = 7;
  localparam int unsigned DEST_LSB = 4;
  localparam int unsigned SEQ_MSB  = 3;
  localparam int unsigned SEQ_LSB  = 0;

  localparam logic [FLIT_W-1:0] IDLE_FLIT = 20'h00000;

  // Flit payload as seen on the link.
  typedef struct packed {
    logic [3:0] ctrl;
    logic [3:0] src;
    logic [3:0] tag;
    logic [3:0] dest;
    logic [3:0] seq;
  } flit_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } sink_state_e;

  // Address width for a capture RAM of the given depth (at least 1 bit).
  function automatic int unsigned ram_addr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/sink_capture_ram.sv
// DEPTH x FLIT_W capture RAM: one write port, registered read with forced-zero option.
//   clk, rst      clock / async active-low reset (read register only)
//   wr_en_i       write strobe; wr_addr_i / wr_data_i write address and data
//   rd_addr_i     read address; rd_zero_i forces the next read result to 0
//   rd_data_o     registered read data, 1-cycle latency, old data on read-during-write
module sink_capture_ram
  import noc_flit_pkg::*;
#(
  parameter int unsigned DEPTH = 30,
  localparam int unsigned AW   = ram_addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en_i,
  input  logic [AW-1:0]     wr_addr_i,
  input  logic [FLIT_W-1:0] wr_data_i,
  input  logic [AW-1:0]     rd_addr_i,
  input  logic              rd_zero_i,
  output logic [FLIT_W-1:0] rd_data_o
);

  logic [FLIT_W-1:0] mem [DEPTH];
  logic [FLIT_W-1:0] rd_data_q;

  // Storage array is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem[wr_addr_i] <= wr_data_i;
  end

  // Out-of-range addresses are flagged by the caller and read back as zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           rd_data_q <= '0;
    else if (rd_zero_i) rd_data_q <= '0;
    else                rd_data_q <= mem[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/datain_sink_buf.sv
// Ejection-side capture buffer: classifies incoming flits, stores those addressed to
// this node in order, counts misroutes/drops and flags completion.
//   clk, rst       clock / async active-low reset
//   clear          sync clear of pointers, counters, flags and FSM (RAM kept)
//   in_valid       flit qualifier; datain 20-bit flit
//   rd_addr        readback address; rd_data registered readback data
//   flit_count     stored flits; misroute_cnt / drop_cnt saturating event counters
//   overflow       sticky full-RAM drop flag; done sticky completion flag
module datain_sink_buf
  import noc_flit_pkg::*;
#(
  parameter int unsigned DEPTH    = 30,
  parameter logic [3:0]  NODE_ID  = 4'd2,
  parameter int unsigned EXPECTED = 7,
  parameter int unsigned TIMEOUT  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [FLIT_W-1:0] datain,
  input  logic [4:0]        rd_addr,
  output logic [FLIT_W-1:0] rd_data,
  output logic [4:0]        flit_count,
  output logic [7:0]        misroute_cnt,
  output logic [7:0]        drop_cnt,
  output logic              overflow,
  output logic              done
);

  localparam int unsigned AW       = ram_addr_w(DEPTH);
  localparam int unsigned IW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT);

  sink_state_e state_q, state_d;
  logic [4:0]    cnt_q, cnt_d;       // doubles as write pointer: capture never wraps
  logic [IW-1:0] idle_q, idle_d;
  logic [7:0]    mis_q, mis_d;
  logic [7:0]    drop_q, drop_d;
  logic          ovf_q, ovf_d;
  logic          done_q, done_d;
  logic          we_c;

  logic live_c, good_c, misroute_c;

  // Flit classification; idle flits are invisible.
  assign live_c     = in_valid && (datain != IDLE_FLIT);
  assign good_c     = live_c && (datain[DEST_MSB:DEST_LSB] == NODE_ID);
  assign misroute_c = live_c && (datain[DEST_MSB:DEST_LSB] != NODE_ID);

  // State and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idle_q  <= '0;
      mis_q   <= '0;
      drop_q  <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idle_q  <= idle_d;
      mis_q   <= mis_d;
      drop_q  <= drop_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  // Next-state, counters and write strobe.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idle_d  = idle_q;
    mis_d   = mis_q;
    drop_d  = drop_q;
    ovf_d   = ovf_q;
    done_d  = done_q;
    we_c    = 1'b0;

    if (clear) begin
      // Any flit in the clear cycle is discarded uncounted.
      state_d = ST_IDLE;
      cnt_d   = '0;
      idle_d  = '0;
      mis_d   = '0;
      drop_d  = '0;
      ovf_d   = 1'b0;
      done_d  = 1'b0;
    end else begin
      if (misroute_c && (mis_q != 8'hFF)) mis_d = mis_q + 8'd1;

      case (state_q)
        ST_IDLE: begin
          if (good_c) begin
            we_c    = 1'b1;
            cnt_d   = cnt_q + 5'd1;
            idle_d  = '0;
            state_d = ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (good_c) begin
            idle_d = '0;
            if (32'(cnt_q) < DEPTH) begin
              we_c  = 1'b1;
              cnt_d = cnt_q + 5'd1;
            end else begin
              if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
              ovf_d = 1'b1;
            end
          end else if (idle_q != IDLE_MAX) begin
            idle_d = idle_q + IW'(1);
          end
        end
        ST_DONE: begin
          if (good_c && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
        end
        default: state_d = ST_IDLE;
      endcase

      // Completion is judged on the post-update values so done lands with the count.
      if ((state_d == ST_CAPTURE) &&
          (((EXPECTED != 0) && (32'(cnt_d) == EXPECTED)) ||
           ((TIMEOUT != 0) && (32'(idle_d) == TIMEOUT)))) begin
        state_d = ST_DONE;
        done_d  = 1'b1;
      end
    end
  end

  sink_capture_ram #(.DEPTH(DEPTH)) u_ram (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (we_c),
    .wr_addr_i (cnt_q[AW-1:0]),
    .wr_data_i (datain),
    .rd_addr_i (rd_addr[AW-1:0]),
    .rd_zero_i (32'(rd_addr) >= DEPTH),
    .rd_data_o (rd_data)
  );

  assign flit_count   = cnt_q;
  assign misroute_cnt = mis_q;
  assign drop_cnt     = drop_q;
  assign overflow     = ovf_q;
  assign done         = done_q;

endmodule
